// File: rtl/drum_pulse_scheduler.sv
// Avalon-MM drum trigger scheduler: queues hit requests (mask + width) and issues them in order
// as timed pulses on out_port once every targeted channel is idle and past its retrigger holdoff.
module drum_pulse_scheduler #(
    parameter int          NUM_CH         = 4,
    parameter int          FIFO_DEPTH     = 4,
    parameter logic [15:0] TICK_DIV_RESET = 16'd49999,
    parameter logic [7:0]  HOLDOFF_RESET  = 8'd0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic [NUM_CH-1:0] out_port
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, EVAL, FIRE} state_t;
    state_t state, state_nxt;

    logic [NUM_CH-1:0] mask_mem  [FIFO_DEPTH];
    logic [7:0]        width_mem [FIFO_DEPTH];
    logic [PTR_W:0]    wr_ptr, rd_ptr, count;
    logic              full, empty;
    logic [15:0]       tick_div, presc;
    logic              tick;
    logic [7:0]        holdoff;
    logic              ovf;
    logic [7:0]        pc [NUM_CH];
    logic [7:0]        hc [NUM_CH];
    logic [NUM_CH-1:0] eligible, head_mask;
    logic [7:0]        head_width;
    logic              wr, trig_valid, push, fire, busy;
    logic              unused_wd;

    assign wr         = chipselect && !write_n;
    assign count      = wr_ptr - rd_ptr;
    assign empty      = (wr_ptr == rd_ptr);
    assign full       = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                        (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign trig_valid = wr && (address == 2'd0) &&
                        (writedata[NUM_CH-1:0] != '0) && (writedata[15:8] != 8'd0);
    // Fullness is judged before any same-cycle pop, so a full FIFO always rejects.
    assign push       = trig_valid && !full;
    assign head_mask  = mask_mem[rd_ptr[PTR_W-1:0]];
    assign head_width = width_mem[rd_ptr[PTR_W-1:0]];
    assign fire       = (state == EVAL) && ((head_mask & ~eligible) == '0);
    assign tick       = (presc == tick_div);
    assign busy       = (|out_port) || (state != IDLE);
    assign unused_wd  = ^writedata[31:16];

    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_CH; i++)
            eligible[i] = !out_port[i] && (hc[i] == 8'd0);
    end

    // Pop and pulse launch happen on the EVAL->FIRE edge; FIRE is the one-cycle settle state.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!empty) state_nxt = EVAL;
            EVAL:    if (fire) state_nxt = FIRE;
            FIRE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            ovf      <= 1'b0;
            tick_div <= TICK_DIV_RESET;
            holdoff  <= HOLDOFF_RESET;
            presc    <= '0;
        end else begin
            state <= state_nxt;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (fire) rd_ptr <= rd_ptr + 1'b1;
            if (trig_valid && full)
                ovf <= 1'b1;
            else if (wr && address == 2'd1)
                ovf <= 1'b0;
            if (wr && address == 2'd2) begin
                tick_div <= writedata[15:0];
                presc    <= '0;
            end else if (tick) begin
                presc <= '0;
            end else begin
                presc <= presc + 16'd1;
            end
            if (wr && address == 2'd3) holdoff <= writedata[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mask_mem[wr_ptr[PTR_W-1:0]]  <= writedata[NUM_CH-1:0];
            width_mem[wr_ptr[PTR_W-1:0]] <= writedata[15:8];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_port <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                pc[i] <= 8'd0;
                hc[i] <= 8'd0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (fire && head_mask[i]) begin
                    out_port[i] <= 1'b1;
                    pc[i]       <= head_width;
                end else if (tick) begin
                    if (out_port[i]) begin
                        if (pc[i] <= 8'd1) begin
                            out_port[i] <= 1'b0;
                            pc[i]       <= 8'd0;
                            hc[i]       <= holdoff;
                        end else begin
                            pc[i] <= pc[i] - 8'd1;
                        end
                    end else if (hc[i] != 8'd0) begin
                        hc[i] <= hc[i] - 8'd1;
                    end
                end
            end
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            2'd1: begin
                readdata[2:0]        = 3'(count);
                readdata[3]          = full;
                readdata[4]          = busy;
                readdata[8 +: NUM_CH] = out_port;
                readdata[12]         = ovf;
            end
            2'd2:    readdata[15:0] = tick_div;
            2'd3:    readdata[7:0]  = holdoff;
            default: readdata = '0;
        endcase
    end
endmodule

// File: tb/tb_drum_pulse_scheduler.sv
// Directed bench for drum_pulse_scheduler: register map, pulse timing, holdoff, ordering,
// overflow and reset flush, with hand-computed expectations.
module tb_drum_pulse_scheduler;
    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [3:0]  out_port;

    int checks = 0;
    int errors = 0;
    int n;
    logic [3:0] exp2 [12];
    logic [3:0] exp3 [14];

    drum_pulse_scheduler dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    task automatic read_chk(input logic [1:0] a, input logic [31:0] exp, input string tag);
        address = a;
        #1;
        check(tag, readdata, exp);
    endtask

    initial begin
        reset = 1'b1; address = '0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
        step(); step();
        check("reset out_port", {28'd0, out_port}, 32'h0);
        read_chk(2'd1, 32'h0, "reset STATUS");
        read_chk(2'd2, 32'd49999, "reset TICK_DIV");
        read_chk(2'd3, 32'h0, "reset HOLDOFF");
        reset = 1'b0;
        step();

        // single pulse, width 3 on ch0+ch2
        write_reg(2'd2, 32'd0);
        write_reg(2'd3, 32'd0);
        write_reg(2'd0, 32'h0305);
        read_chk(2'd1, 32'h1, "t1 STATUS N");
        check("t1 out N", {28'd0, out_port}, 32'h0);
        step();
        read_chk(2'd1, 32'h11, "t1 STATUS N+1");
        check("t1 out N+1", {28'd0, out_port}, 32'h0);
        step();
        read_chk(2'd1, 32'h510, "t1 STATUS N+2");
        check("t1 out N+2", {28'd0, out_port}, 32'h5);
        step();
        check("t1 out N+3", {28'd0, out_port}, 32'h5);
        step();
        check("t1 out N+4", {28'd0, out_port}, 32'h5);
        step();
        check("t1 out N+5", {28'd0, out_port}, 32'h0);
        step();
        read_chk(2'd1, 32'h0, "t1 STATUS idle");

        // holdoff 4 between two ch0 pulses of width 2
        write_reg(2'd3, 32'd4);
        read_chk(2'd3, 32'd4, "t2 HOLDOFF rb");
        exp2 = '{4'h0, 4'h0, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h1, 4'h0};
        write_reg(2'd0, 32'h0201);
        write_reg(2'd0, 32'h0201);
        check("t2 out k=1", {28'd0, out_port}, {28'd0, exp2[1]});
        for (int k = 2; k < 12; k++) begin
            step();
            check($sformatf("t2 out k=%0d", k), {28'd0, out_port}, {28'd0, exp2[k]});
        end
        write_reg(2'd3, 32'd0);
        repeat (5) step();

        // head-of-line blocking: ch2 request waits behind second ch1 request
        exp3 = '{4'h0, 4'h0, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h0, 4'h2, 4'h0, 4'h0, 4'h4, 4'h0};
        write_reg(2'd0, 32'h0602);
        write_reg(2'd0, 32'h0102);
        write_reg(2'd0, 32'h0104);
        read_chk(2'd1, 32'h212, "t3 STATUS B+2");
        check("t3 out k=2", {28'd0, out_port}, {28'd0, exp3[2]});
        for (int k = 3; k < 14; k++) begin
            step();
            check($sformatf("t3 out k=%0d", k), {28'd0, out_port}, {28'd0, exp3[k]});
        end
        repeat (3) step();

        // ignored requests: mask 0 or width 0
        write_reg(2'd0, 32'h0100);
        write_reg(2'd0, 32'h0001);
        step(); step();
        read_chk(2'd1, 32'h0, "t5 ignored STATUS");
        check("t5 ignored out", {28'd0, out_port}, 32'h0);

        // TICK_DIV=3, width 2 on ch3
        write_reg(2'd2, 32'd3);
        write_reg(2'd0, 32'h0208);
        step();
        check("t5 out D+2", {28'd0, out_port}, 32'h0);
        step();
        check("t5 out D+3", {28'd0, out_port}, 32'h8);
        n = 1;
        for (int k = 0; k < 20; k++) begin
            step();
            if (out_port == 4'h8) n++;
            else break;
        end
        check("t5 pulse len 5..8", {31'd0, (n >= 5 && n <= 8)}, 32'h1);
        write_reg(2'd2, 32'd0);
        step();

        // overflow with ch0 blocked by a 255-tick pulse
        write_reg(2'd0, 32'hFF01);
        step(); step();
        for (int k = 0; k < 5; k++) write_reg(2'd0, 32'h0101);
        read_chk(2'd1, 32'h111C, "t4 STATUS full+ovf");
        read_chk(2'd0, 32'h0, "t4 TRIG reads 0");
        write_reg(2'd1, 32'h0);
        read_chk(2'd1, 32'h011C, "t4 STATUS ovf clr");
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();

        // reset mid-pulse with three queued requests
        write_reg(2'd0, 32'h3201);
        step(); step();
        for (int k = 0; k < 3; k++) write_reg(2'd0, 32'h0101);
        read_chk(2'd1, 32'h113, "t6 STATUS pre-reset");
        write_reg(2'd3, 32'h22);
        write_reg(2'd2, 32'h1234);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("t6 out after reset", {28'd0, out_port}, 32'h0);
        read_chk(2'd1, 32'h0, "t6 STATUS after reset");
        read_chk(2'd2, 32'd49999, "t6 TICK_DIV after reset");
        read_chk(2'd3, 32'h0, "t6 HOLDOFF after reset");
        step(); step();
        check("t6 out stays 0", {28'd0, out_port}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
